// File: rtl/pipeline_ctrl_pkg.sv
// Shared constants and types for the core's stall/flush scheduler.
// Holds the RV32 opcodes the scheduler decodes and the next-PC select encodings.
package pipeline_ctrl_pkg;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;

   localparam logic [1:0] REDIRECT_PC4 = 2'd0;
   localparam logic [1:0] REDIRECT_ID  = 2'd1;
   localparam logic [1:0] REDIRECT_EX  = 2'd2;

   typedef enum logic {
      MODE_RUN    = 1'b0,
      MODE_FREEZE = 1'b1
   } mode_e;

   // One cycle's worth of pipeline controls, produced as a unit so they stay consistent.
   typedef struct packed {
      logic       pipe_freeze;
      logic       pc_stall;
      logic       id_stall;
      logic       ex_bubble;
      logic [1:0] redirect_sel;
      logic       set_flush;
      logic       redirect;
   } ctrl_t;

   function automatic logic reads_reg(input logic uses, input logic [4:0] rs,
                                      input logic [4:0] rd);
      return uses && (rs == rd);
   endfunction

endpackage

// File: rtl/pipeline_ctrl_event_counter.sv
// Free-running wrapping event counter with enable; async active-high reset.
module event_counter
#(
   parameter int CNT_W = 32
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         count <= '0;
      else if (en)
         count <= count + 1'b1;
   end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush scheduler for the 4-stage core: arbitrates memory freezes, EX branches,
// load-use hazards and ID jumps into one set of hold/flush/bubble/PC-select controls.
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int CNT_W = 32
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic [6:0]       id_opcode,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_uses_rs1,
   input  logic             id_uses_rs2,
   input  logic [6:0]       ex_opcode,
   input  logic [4:0]       ex_rd,
   input  logic             ex_branch_taken,
   input  logic             mem_busy,
   output logic             pipe_freeze,
   output logic             pc_stall,
   output logic             id_stall,
   output logic             id_flush,
   output logic             ex_bubble,
   output logic [1:0]       redirect_sel,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] redirect_count
);

   mode_e mode;
   logic  flush_pending;
   logic  id_valid;
   logic  load_use;
   logic  id_jump;
   ctrl_t ctrl;

   // The word in ID right after a redirect (or reset) is wrong-path; its hazards are ignored.
   assign id_valid = !flush_pending;

   assign load_use = (ex_opcode == OPC_LOAD) && (ex_rd != 5'd0) && id_valid &&
                     (reads_reg(id_uses_rs1, id_rs1, ex_rd) ||
                      reads_reg(id_uses_rs2, id_rs2, ex_rd));

   assign id_jump = ((id_opcode == OPC_JAL) || (id_opcode == OPC_JALR)) && id_valid;

   always_comb begin
      ctrl = '0;
      ctrl.redirect_sel = REDIRECT_PC4;
      if (rst) begin
         ctrl.pc_stall  = 1'b1;
         ctrl.ex_bubble = 1'b1;
      end else if (mem_busy) begin
         ctrl.pipe_freeze = 1'b1;
         ctrl.pc_stall    = 1'b1;
         ctrl.id_stall    = 1'b1;
      end else if (ex_branch_taken) begin
         ctrl.redirect_sel = REDIRECT_EX;
         ctrl.ex_bubble    = 1'b1;
         ctrl.set_flush    = 1'b1;
         ctrl.redirect     = 1'b1;
      end else if (load_use) begin
         ctrl.pc_stall  = 1'b1;
         ctrl.id_stall  = 1'b1;
         ctrl.ex_bubble = 1'b1;
      end else if (id_jump) begin
         ctrl.redirect_sel = REDIRECT_ID;
         ctrl.set_flush    = 1'b1;
         ctrl.redirect     = 1'b1;
      end
   end

   // A freeze holds flush_pending so the kill lands on the first non-frozen cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode          <= MODE_RUN;
         flush_pending <= 1'b1;
      end else begin
         case (mode)
            MODE_RUN:    if (mem_busy)  mode <= MODE_FREEZE;
            MODE_FREEZE: if (!mem_busy) mode <= MODE_RUN;
            default:     mode <= MODE_RUN;
         endcase
         if (!mem_busy)
            flush_pending <= ctrl.set_flush;
      end
   end

   assign pipe_freeze  = ctrl.pipe_freeze;
   assign pc_stall     = ctrl.pc_stall;
   assign id_stall     = ctrl.id_stall;
   assign ex_bubble    = ctrl.ex_bubble;
   assign redirect_sel = ctrl.redirect_sel;
   assign id_flush     = flush_pending;

   event_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .en    (ctrl.pc_stall),
      .count (stall_cycles)
   );

   event_counter #(.CNT_W(CNT_W)) u_redirect_cnt (
      .clk   (clk),
      .rst   (rst),
      .en    (ctrl.redirect),
      .count (redirect_count)
   );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed scoreboard bench for pipeline_ctrl (4-bit counters to reach wrap quickly).
module tb_pipeline_ctrl;

   localparam int W = 4;
   localparam logic [6:0] LD   = 7'b0000011;
   localparam logic [6:0] NOP  = 7'b0010011;
   localparam logic [6:0] ADD  = 7'b0110011;
   localparam logic [6:0] BR   = 7'b1100011;
   localparam logic [6:0] JALR = 7'b1100111;
   localparam logic [6:0] JAL  = 7'b1101111;

   // expected vector: {pipe_freeze, pc_stall, id_stall, id_flush, ex_bubble, redirect_sel[1:0]}
   localparam logic [6:0] E_RST   = 7'b0101100;
   localparam logic [6:0] E_IDLE  = 7'b0000000;
   localparam logic [6:0] E_FLUSH = 7'b0001000;
   localparam logic [6:0] E_LU    = 7'b0110100;
   localparam logic [6:0] E_BR    = 7'b0000110;
   localparam logic [6:0] E_JMP   = 7'b0000001;
   localparam logic [6:0] E_FRZF  = 7'b1111000;
   localparam logic [6:0] E_FRZ   = 7'b1110000;

   logic         clk = 1'b0;
   logic         rst;
   logic [6:0]   id_opcode, ex_opcode;
   logic [4:0]   id_rs1, id_rs2, ex_rd;
   logic         id_uses_rs1, id_uses_rs2, ex_branch_taken, mem_busy;
   logic         pipe_freeze, pc_stall, id_stall, id_flush, ex_bubble;
   logic [1:0]   redirect_sel;
   logic [W-1:0] stall_cycles, redirect_count;

   int checks = 0;
   int failures = 0;
   logic [6:0] sb[$];

   always #5 clk = ~clk;

   pipeline_ctrl #(.CNT_W(W)) dut (
      .clk(clk), .rst(rst),
      .id_opcode(id_opcode), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
      .ex_opcode(ex_opcode), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
      .mem_busy(mem_busy),
      .pipe_freeze(pipe_freeze), .pc_stall(pc_stall), .id_stall(id_stall),
      .id_flush(id_flush), .ex_bubble(ex_bubble), .redirect_sel(redirect_sel),
      .stall_cycles(stall_cycles), .redirect_count(redirect_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle's inputs after the falling edge, push the expected controls,
   // then pop and compare them 1ns later, well before the next rising edge.
   task automatic step(input string tag, input logic r, input logic [6:0] iop,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2,
                       input logic [6:0] eop, input logic [4:0] erd,
                       input logic br, input logic mb, input logic [6:0] exp);
      logic [6:0] got;
      logic [6:0] want;
      @(negedge clk);
      rst = r; id_opcode = iop; id_rs1 = rs1; id_rs2 = rs2;
      id_uses_rs1 = u1; id_uses_rs2 = u2; ex_opcode = eop; ex_rd = erd;
      ex_branch_taken = br; mem_busy = mb;
      sb.push_back(exp);
      #1;
      got  = {pipe_freeze, pc_stall, id_stall, id_flush, ex_bubble, redirect_sel};
      want = sb.pop_front();
      chk(tag, {25'd0, got}, {25'd0, want});
   endtask

   task automatic idle(input string tag, input logic [6:0] exp);
      step(tag, 1'b0, NOP, 5'd0, 5'd0, 1'b0, 1'b0, NOP, 5'd0, 1'b0, 1'b0, exp);
   endtask

   task automatic busy(input string tag, input logic [6:0] exp);
      step(tag, 1'b0, NOP, 5'd0, 5'd0, 1'b0, 1'b0, NOP, 5'd0, 1'b0, 1'b1, exp);
   endtask

   initial begin
      rst = 1'b1; id_opcode = NOP; id_rs1 = '0; id_rs2 = '0; id_uses_rs1 = 1'b0;
      id_uses_rs2 = 1'b0; ex_opcode = NOP; ex_rd = '0; ex_branch_taken = 1'b0;
      mem_busy = 1'b0;

      // reset held three cycles, then the first post-reset word is killed
      for (int i = 0; i < 3; i++)
         step("reset_hold", 1'b1, NOP, 5'd0, 5'd0, 1'b0, 1'b0, NOP, 5'd0, 1'b0, 1'b0, E_RST);
      idle("reset_first", E_FLUSH);
      chk("reset_stall_cnt", {28'd0, stall_cycles}, 32'd0);
      chk("reset_redir_cnt", {28'd0, redirect_count}, 32'd0);
      idle("reset_second", E_IDLE);

      // load-use: EX=LW x5, ID=ADD x6,x5,x1 stalls one cycle only
      step("lu_stall", 1'b0, ADD, 5'd5, 5'd1, 1'b1, 1'b1, LD, 5'd5, 1'b0, 1'b0, E_LU);
      step("lu_release", 1'b0, ADD, 5'd5, 5'd1, 1'b1, 1'b1, NOP, 5'd0, 1'b0, 1'b0, E_IDLE);
      chk("lu_stall_cnt", {28'd0, stall_cycles}, 32'd1);

      // load to x0 never stalls
      step("lu_x0", 1'b0, ADD, 5'd0, 5'd0, 1'b1, 1'b1, LD, 5'd0, 1'b0, 1'b0, E_IDLE);

      // taken branch beats ID JAL; the next JAL in ID is wrong-path
      step("br_win", 1'b0, JAL, 5'd0, 5'd0, 1'b0, 1'b0, BR, 5'd0, 1'b1, 1'b0, E_BR);
      step("br_kill", 1'b0, JAL, 5'd0, 5'd0, 1'b0, 1'b0, NOP, 5'd0, 1'b0, 1'b0, E_FLUSH);
      chk("br_redir_cnt", {28'd0, redirect_count}, 32'd1);
      idle("br_after", E_IDLE);

      // branch together with a load-use: branch wins, no stall counted
      step("br_over_lu", 1'b0, ADD, 5'd7, 5'd0, 1'b1, 1'b0, LD, 5'd7, 1'b1, 1'b0, E_BR);
      idle("br_over_lu_f", E_FLUSH);
      chk("br_lu_stall_cnt", {28'd0, stall_cycles}, 32'd1);
      chk("br_lu_redir_cnt", {28'd0, redirect_count}, 32'd2);

      // JALR waiting on a load: stall, redirect, then flush
      step("jalr_stall", 1'b0, JALR, 5'd1, 5'd0, 1'b1, 1'b0, LD, 5'd1, 1'b0, 1'b0, E_LU);
      step("jalr_redir", 1'b0, JALR, 5'd1, 5'd0, 1'b1, 1'b0, NOP, 5'd0, 1'b0, 1'b0, E_JMP);
      idle("jalr_flush", E_FLUSH);
      chk("jalr_stall_cnt", {28'd0, stall_cycles}, 32'd2);
      chk("jalr_redir_cnt", {28'd0, redirect_count}, 32'd3);

      // JAL redirect, then a 4-cycle freeze holds the pending flush
      step("frz_jal", 1'b0, JAL, 5'd0, 5'd0, 1'b0, 1'b0, NOP, 5'd0, 1'b0, 1'b0, E_JMP);
      for (int i = 0; i < 4; i++) busy("frz_hold", E_FRZF);
      idle("frz_flush", E_FLUSH);
      idle("frz_done", E_IDLE);
      chk("frz_stall_cnt", {28'd0, stall_cycles}, 32'd6);
      chk("frz_redir_cnt", {28'd0, redirect_count}, 32'd4);

      // freeze, then reset asserted mid-freeze
      busy("rst_frz_busy", E_FRZ);
      step("rst_mid_frz", 1'b1, NOP, 5'd0, 5'd0, 1'b0, 1'b0, NOP, 5'd0, 1'b0, 1'b1, E_RST);
      chk("rst_mid_stall_cnt", {28'd0, stall_cycles}, 32'd0);
      chk("rst_mid_redir_cnt", {28'd0, redirect_count}, 32'd0);

      // post-reset flush cycle ignores a JAL, then 17 stalls wrap a 4-bit counter to 1
      step("wrap_first", 1'b0, JAL, 5'd0, 5'd0, 1'b0, 1'b0, NOP, 5'd0, 1'b0, 1'b0, E_FLUSH);
      chk("wrap_jal_ignored", {28'd0, redirect_count}, 32'd0);
      for (int i = 0; i < 17; i++) busy("wrap_busy", E_FRZ);
      idle("wrap_end", E_IDLE);
      chk("wrap_stall_cnt", {28'd0, stall_cycles}, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
